// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I field encoder / instruction-memory loader.
package instr_encoder_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    KIND_LOAD   = 3'd0,
    KIND_STORE  = 3'd1,
    KIND_RTYPE  = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_ITYPE  = 3'd4,
    KIND_JAL    = 3'd5,
    KIND_ILL6   = 3'd6,
    KIND_ILL7   = 3'd7
  } kind_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  localparam int unsigned IMM_I_BITS = 12;
  localparam int unsigned IMM_S_BITS = 12;
  localparam int unsigned IMM_B_BITS = 13;
  localparam int unsigned IMM_J_BITS = 21;

  typedef struct packed {
    kind_e        kind;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  imm;
  } fields_t;

  // True when imm is representable as a signed value of the given bit count.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (bits - 1);
    return ((imm & mask) == 32'h0) || ((imm & mask) == mask);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: decoded fields -> 32-bit RV32I word plus error flags.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t              fields_i,
  output logic [INSTR_W-1:0]   instr_o,
  output logic                 range_err_o,
  output logic                 illegal_o
);

  logic [31:0] imm;
  logic [2:0]  f3;
  logic [6:0]  funct7;

  assign imm    = fields_i.imm;
  assign f3     = fields_i.funct3;
  assign funct7 = {1'b0, fields_i.funct7b5, 5'b00000};

  always_comb begin
    instr_o     = NOP;
    range_err_o = 1'b0;
    illegal_o   = 1'b0;
    case (fields_i.kind)
      KIND_LOAD, KIND_ITYPE: begin
        instr_o = {imm[11:0], fields_i.rs1, f3, fields_i.rd,
                   (fields_i.kind == KIND_LOAD) ? OP_LOAD : OP_I};
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (fields_i.kind == KIND_ITYPE && (f3 == 3'b001 || f3 == 3'b101))
          instr_o[31:20] = {funct7, imm[4:0]};
        range_err_o = !imm_fits(imm, IMM_I_BITS);
      end
      KIND_STORE: begin
        instr_o = {imm[11:5], fields_i.rs2, fields_i.rs1, f3, imm[4:0], OP_STORE};
        range_err_o = !imm_fits(imm, IMM_S_BITS);
      end
      KIND_RTYPE: begin
        instr_o = {funct7, fields_i.rs2, fields_i.rs1, f3, fields_i.rd, OP_R};
      end
      KIND_BRANCH: begin
        instr_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, f3,
                   imm[4:1], imm[11], OP_B};
        range_err_o = !imm_fits(imm, IMM_B_BITS) || imm[0];
      end
      KIND_JAL: begin
        instr_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, OP_JAL};
        range_err_o = !imm_fits(imm, IMM_J_BITS) || imm[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes field bundles and streams words with sequential addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_kind,
  input  logic [2:0]          in_funct3,
  input  logic                in_funct7b5,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  fields_t              fields;
  logic [INSTR_W-1:0]   pack_instr;
  logic                 pack_range_err;
  logic                 pack_illegal;

  logic                 out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]    next_addr_q, next_addr_d;
  logic [CNT_W-1:0]     accepted_q, accepted_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 err_q, err_d;

  logic                 full_pending;
  logic                 in_fire;
  logic                 out_fire;

  assign fields = '{kind:     kind_e'(in_kind),
                    funct3:   in_funct3,
                    funct7b5: in_funct7b5,
                    rd:       in_rd,
                    rs1:      in_rs1,
                    rs2:      in_rs2,
                    imm:      in_imm};

  instr_pack u_pack (
    .fields_i    (fields),
    .instr_o     (pack_instr),
    .range_err_o (pack_range_err),
    .illegal_o   (pack_illegal)
  );

  assign full_pending = (accepted_q == CNT_W'(DEPTH));
  assign in_ready     = !start && !full_pending && (!out_valid_q || out_ready);
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    next_addr_d = next_addr_q;
    accepted_d  = accepted_q;
    count_d     = count_q;
    err_d       = err_q;

    if (in_fire) begin
      out_valid_d = 1'b1;
      out_instr_d = pack_instr;
      out_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(1);
      accepted_d  = accepted_q + CNT_W'(1);
      if (pack_range_err || pack_illegal)
        err_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (out_fire)
      count_d = count_q + CNT_W'(1);

    // A word still waiting in the output register is carried into the new run.
    if (start) begin
      next_addr_d = '0;
      count_d     = '0;
      err_d       = 1'b0;
      accepted_d  = (out_valid_q && !out_ready) ? CNT_W'(1) : CNT_W'(0);
    end

    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      next_addr_q <= '0;
      accepted_q  <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
      next_addr_q <= next_addr_d;
      accepted_q  <= accepted_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_instr = out_instr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder (DEPTH=4 so the full condition is reachable).
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
  } exp_t;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  bit                taken;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_instr   (out_instr),
    .count       (count),
    .full        (full),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offers one field bundle; pushes the expected word when the handshake will complete.
  task automatic send(input logic [2:0] kind, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp_instr,
                      input int budget, output bit ok);
    in_kind = kind; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{addr: exp_addr, instr: exp_instr});
        exp_addr = exp_addr + ADDR_W'(1);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_addr = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_kind = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    // Output-side scoreboard: every completed transfer must match the oldest expectation.
    fork
      forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
          n_checks++;
          assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL spurious_word: observed word at addr %0d, expected none", out_addr);
          end
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_instr", out_instr, e.instr);
            check("sb_addr", 32'(out_addr), 32'(e.addr));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr",  32'(out_addr),  32'd0);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_full",      32'(full),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single ITYPE addi x1, x0, 5
    pulse_start();
    send(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 10, taken);
    check("accept_addi", 32'(taken), 32'd1);
    idle();
    drain("drain_addi");
    check("count_after_addi", 32'(count), 32'd1);

    // Back-to-back words fill DEPTH=4
    pulse_start();
    send(3'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8, 32'h0080_A103, 1, taken);
    check("b2b_load", 32'(taken), 32'd1);
    send(3'd1, 3'b010, 1'b0, 5'd0, 5'd0, 5'd2, 32'd4, 32'h0020_2223, 1, taken);
    check("b2b_store", 32'(taken), 32'd1);
    send(3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1, taken);
    check("b2b_add", 32'(taken), 32'd1);
    send(3'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1, taken);
    check("b2b_sub", 32'(taken), 32'd1);
    idle();
    drain("drain_b2b");
    check("count_full", 32'(count), 32'd4);
    check("full_set", 32'(full), 32'd1);
    @(negedge clk);
    check("in_ready_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    send(3'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8, 32'h0080_A103, 6, taken);
    check("fifth_rejected", 32'(taken), 32'd0);
    idle();
    check("count_stays_full", 32'(count), 32'd4);

    // start clears full; branch/jal start at address 0
    pulse_start();
    check("full_cleared", 32'(full), 32'd0);
    check("count_cleared", 32'(count), 32'd0);
    send(3'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 10, taken);
    check("accept_beq", 32'(taken), 32'd1);
    send(3'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h0080_006F, 10, taken);
    check("accept_jal", 32'(taken), 32'd1);
    idle();
    drain("drain_bj");
    check("err_clean", 32'(err), 32'd0);
    check("count_bj", 32'(count), 32'd2);

    // Backpressure: word must hold steady and in_ready must drop
    out_ready = 1'b0;
    send(3'd4, 3'b000, 1'b0, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_8293, 10, taken);
    check("accept_bp", 32'(taken), 32'd1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_instr", out_instr, 32'hFFF0_8293);
      check("bp_addr", 32'(out_addr), 32'd2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_bp");
    check("count_bp", 32'(count), 32'd3);
    send(3'd4, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 10, taken);
    check("accept_srai", 32'(taken), 32'd1);
    idle();
    drain("drain_srai");
    check("err_srai", 32'(err), 32'd0);

    // Error cases
    pulse_start();
    send(3'd7, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, 10, taken);
    check("accept_illegal", 32'(taken), 32'd1);
    idle();
    drain("drain_illegal");
    check("err_illegal", 32'(err), 32'd1);
    pulse_start();
    check("err_cleared_1", 32'(err), 32'd0);
    send(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 10, taken);
    check("accept_big_imm", 32'(taken), 32'd1);
    idle();
    drain("drain_big_imm");
    check("err_range", 32'(err), 32'd1);
    pulse_start();
    check("err_cleared_2", 32'(err), 32'd0);
    send(3'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 32'h0020_8263, 10, taken);
    check("accept_odd_br", 32'(taken), 32'd1);
    idle();
    drain("drain_odd_br");
    check("err_odd", 32'(err), 32'd1);
    pulse_start();
    check("err_cleared_3", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
